bcd_display_scanner: RTL and testbench



---
 rtl/bcd_display_scanner_if.sv | 23 ++
 rtl/bcd_display_scanner.sv | 121 ++++++++++++
 tb/tb_bcd_display_scanner.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_scanner_if.sv
// Bundle between the binary source / 7-segment decoder and the BCD display scanner.
// The scanner side takes value/load and drives status plus the scanned digit outputs.
interface bcd_display_scanner_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
);
    logic [BIN_W-1:0]      value_in;
    logic                  load;
    logic                  busy;
    logic                  overflow;
    logic [3:0]            digit;
    logic [NUM_DIGITS-1:0] digit_sel;

    modport master (
        output value_in, load,
        input  busy, overflow, digit, digit_sel
    );

    modport slave (
        input  value_in, load,
        output busy, overflow, digit, digit_sel
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD (shift-add-3, BIN_W+1 busy cycles) feeding a time-multiplexed digit scanner.
// Output latency is one registered cycle; a load is dropped while busy, and nothing is queued.
module bcd_display_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int BIN_W         = 14,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_display_scanner_if.slave  bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(pow10(NUM_DIGITS) - 1);
    localparam logic [BCD_W-1:0] ALL_NINE = {NUM_DIGITS{4'd9}};

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                state;
    logic [BIN_W-1:0]      bin_sr;
    logic [BCD_W-1:0]      bcd_sr;
    logic [BCD_W-1:0]      bcd_adj;
    logic [BCD_W-1:0]      disp;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  ovf_cap;
    logic [REF_W-1:0]      ref_cnt;
    logic [IDX_W-1:0]      idx;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_run;
    logic [3:0]            digit_nxt;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    // Conversion runs on private shift registers; disp only changes in COMMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bin_sr       <= '0;
            bcd_sr       <= '0;
            bit_cnt      <= '0;
            ovf_cap      <= 1'b0;
            disp         <= '0;
            bus.busy     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        bin_sr   <= bus.value_in;
                        bcd_sr   <= '0;
                        bit_cnt  <= '0;
                        ovf_cap  <= (bus.value_in > MAX_VAL);
                        bus.busy <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    bit_cnt          <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(BIN_W - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    disp         <= ovf_cap ? ALL_NINE : bcd_sr;
                    bus.overflow <= ovf_cap;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (disp[4*i +: 4] == 4'd0);
            lead_zero[i] = zero_run;
        end
    end

    always_comb begin
        digit_nxt = disp[idx*4 +: 4];
        if ((BLANK_LEADING != 0) && (idx != '0) && lead_zero[idx]) digit_nxt = 4'hF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt       <= '0;
            idx           <= '0;
            bus.digit_sel <= NUM_DIGITS'(1);
            bus.digit     <= 4'h0;
        end else begin
            if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                idx     <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            bus.digit_sel <= NUM_DIGITS'(1) << idx;
            bus.digit     <= digit_nxt;
        end
    end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with a fast refresh; a second instance checks unblanked output.
module tb_bcd_display_scanner;
    localparam int ND = 4;
    localparam int BW = 14;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bcd_display_scanner_if #(.NUM_DIGITS(ND), .BIN_W(BW)) bus ();
    bcd_display_scanner_if #(.NUM_DIGITS(ND), .BIN_W(BW)) bus_nb ();

    assign bus_nb.value_in = bus.value_in;
    assign bus_nb.load     = bus.load;

    bcd_display_scanner #(.NUM_DIGITS(ND), .BIN_W(BW), .REFRESH_DIV(RD), .BLANK_LEADING(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    bcd_display_scanner #(.NUM_DIGITS(ND), .BIN_W(BW), .REFRESH_DIV(RD), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .rst(rst), .bus(bus_nb)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_load(input logic [BW-1:0] v, input logic [15:0] old,
                            output int cycles, output bit hold_ok, output bit ovf_stable);
        logic ovf0;
        bus.value_in = v;
        bus.load     = 1'b1;
        step(1);
        bus.load   = 1'b0;
        ovf0       = bus.overflow;
        cycles     = 0;
        hold_ok    = 1'b1;
        ovf_stable = 1'b1;
        while (bus.busy && cycles < 100) begin
            cycles++;
            if (bus.overflow !== ovf0) ovf_stable = 1'b0;
            for (int i = 0; i < ND; i++)
                if (bus.digit_sel == (ND'(1) << i) && bus.digit !== old[4*i +: 4]) hold_ok = 1'b0;
            step(1);
        end
    endtask

    task automatic read_digits(output logic [15:0] m, output logic [15:0] n, output int misses);
        int w;
        m = '0; n = '0; misses = 0;
        step(1);
        for (int d = 0; d < ND; d++) begin
            w = 0;
            while (bus.digit_sel !== (ND'(1) << d) && w < 40) begin
                step(1);
                w++;
            end
            if (w >= 40) misses++;
            else begin
                m[4*d +: 4] = bus.digit;
                n[4*d +: 4] = bus_nb.digit;
            end
        end
    endtask

    task automatic test_reset();
        logic [ND-1:0] sel_seq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [3:0]    dig_seq [5] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hF};
        rst = 1'b1; bus.load = 1'b0; bus.value_in = '0;
        step(3);
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
        total++; if (bus.digit_sel !== 4'b0001) begin bad++; $display("FAIL reset_sel got=%b want=0001", bus.digit_sel); end
        total++; if (bus.digit !== 4'h0) begin bad++; $display("FAIL reset_digit got=%h want=0", bus.digit); end
        step(4);
        total++; if (bus.digit_sel !== 4'b0001) begin bad++; $display("FAIL scan_first_dwell got=%b want=0001", bus.digit_sel); end
        for (int k = 0; k < 5; k++) begin
            step(1);
            total++;
            if (bus.digit_sel !== sel_seq[k] || bus.digit !== dig_seq[k]) begin
                bad++;
                $display("FAIL scan_step%0d got=%b/%h want=%b/%h", k, bus.digit_sel, bus.digit, sel_seq[k], dig_seq[k]);
            end
            step(3);
            total++;
            if (bus.digit_sel !== sel_seq[k]) begin
                bad++;
                $display("FAIL scan_dwell%0d got=%b want=%b", k, bus.digit_sel, sel_seq[k]);
            end
        end
    endtask

    task automatic test_convert();
        int cyc; bit hold, ovs; logic [15:0] m, n; int miss;
        run_load(14'd1234, 16'hFFF0, cyc, hold, ovs);
        total++; if (cyc !== 15) begin bad++; $display("FAIL convert_busy got=%0d want=15", cyc); end
        total++; if (hold !== 1'b1) begin bad++; $display("FAIL convert_hold got=%b want=1", hold); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL convert_ovf got=%b want=0", bus.overflow); end
        read_digits(m, n, miss);
        total++; if (miss !== 0 || m !== 16'h1234) begin bad++; $display("FAIL convert_digits got=%h miss=%0d want=1234", m, miss); end
    endtask

    task automatic test_blanking();
        logic [BW-1:0] vals [4] = '{14'd7, 14'd1000, 14'd0, 14'd105};
        logic [15:0]   em   [4] = '{16'hFFF7, 16'h1000, 16'hFFF0, 16'hF105};
        logic [15:0]   en   [4] = '{16'h0007, 16'h1000, 16'h0000, 16'h0105};
        logic [15:0]   old;
        int cyc; bit hold, ovs; logic [15:0] m, n; int miss;
        old = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            run_load(vals[k], old, cyc, hold, ovs);
            read_digits(m, n, miss);
            total++;
            if (cyc !== 15 || hold !== 1'b1) begin bad++; $display("FAIL blank_busy%0d got=%0d/%b want=15/1", k, cyc, hold); end
            total++;
            if (miss !== 0 || m !== em[k]) begin bad++; $display("FAIL blank_lead%0d got=%h want=%h", k, m, em[k]); end
            total++;
            if (miss !== 0 || n !== en[k]) begin bad++; $display("FAIL blank_off%0d got=%h want=%h", k, n, en[k]); end
            old = em[k];
        end
    endtask

    task automatic test_overflow();
        logic [BW-1:0] vals [4] = '{14'd12000, 14'd9999, 14'd10000, 14'd5};
        logic          eo   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0]   ed   [4] = '{16'h9999, 16'h9999, 16'h9999, 16'hFFF5};
        logic [15:0]   old;
        int cyc; bit hold, ovs; logic [15:0] m, n; int miss;
        old = 16'hF105;
        for (int k = 0; k < 4; k++) begin
            run_load(vals[k], old, cyc, hold, ovs);
            total++;
            if (ovs !== 1'b1) begin bad++; $display("FAIL ovf_stable%0d got=%b want=1", k, ovs); end
            total++;
            if (bus.overflow !== eo[k]) begin bad++; $display("FAIL ovf_flag%0d got=%b want=%b", k, bus.overflow, eo[k]); end
            read_digits(m, n, miss);
            total++;
            if (miss !== 0 || m !== ed[k]) begin bad++; $display("FAIL ovf_digits%0d got=%h want=%h", k, m, ed[k]); end
            old = ed[k];
        end
    endtask

    task automatic test_busy_ignore();
        int cyc; logic [15:0] m, n; int miss;
        bus.value_in = 14'd1234;
        bus.load     = 1'b1;
        step(1);
        bus.load = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            if (cyc == 3 || cyc == 14) begin bus.value_in = 14'd5678; bus.load = 1'b1; end
            else bus.load = 1'b0;
            step(1);
        end
        bus.load = 1'b0;
        total++; if (cyc !== 15) begin bad++; $display("FAIL ignore_busy got=%0d want=15", cyc); end
        step(3);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_noqueue got=%b want=0", bus.busy); end
        read_digits(m, n, miss);
        total++; if (miss !== 0 || m !== 16'h1234) begin bad++; $display("FAIL ignore_digits got=%h want=1234", m); end
    endtask

    task automatic test_back_to_back();
        int c1, gap, c2; logic [15:0] m, n; int miss;
        bus.value_in = 14'd42;
        bus.load     = 1'b1;
        step(1);
        bus.value_in = 14'd77;
        c1 = 0;
        while (bus.busy && c1 < 100) begin c1++; step(1); end
        gap = 0;
        while (!bus.busy && gap < 10) begin gap++; step(1); end
        bus.load = 1'b0;
        c2 = 0;
        while (bus.busy && c2 < 100) begin c2++; step(1); end
        total++;
        if (c1 !== 15 || gap !== 1 || c2 !== 15) begin
            bad++;
            $display("FAIL b2b_timing got=%0d/%0d/%0d want=15/1/15", c1, gap, c2);
        end
        read_digits(m, n, miss);
        total++; if (miss !== 0 || m !== 16'hFF77) begin bad++; $display("FAIL b2b_digits got=%h want=FF77", m); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit hold, ovs; logic [15:0] m, n; int miss;
        run_load(14'd1234, 16'hFF77, cyc, hold, ovs);
        bus.value_in = 14'd4321;
        bus.load     = 1'b1;
        step(1);
        bus.load = 1'b0;
        step(5);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy6 got=%b want=1", bus.busy); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.digit_sel !== 4'b0001 || bus.digit !== 4'h0 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_state got=%b/%b/%h/%b want=0/0001/0/0", bus.busy, bus.digit_sel, bus.digit, bus.overflow);
        end
        read_digits(m, n, miss);
        total++; if (miss !== 0 || m !== 16'hFFF0) begin bad++; $display("FAIL rstmid_cleared got=%h want=FFF0", m); end
        run_load(14'd4321, 16'hFFF0, cyc, hold, ovs);
        total++; if (cyc !== 15 || hold !== 1'b1) begin bad++; $display("FAIL rstmid_reload got=%0d/%b want=15/1", cyc, hold); end
        read_digits(m, n, miss);
        total++; if (miss !== 0 || m !== 16'h4321) begin bad++; $display("FAIL rstmid_digits got=%h want=4321", m); end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_blanking();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
